// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects raw buttons and switches.
// Define INPUT_CONDITIONER_AUTOREPEAT_EN to add auto-repeat pulses on held buttons.
module input_conditioner #(
  parameter int N_BTN           = 5,
  parameter int N_SW            = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw
);

  localparam int N_CH  = N_BTN + N_SW;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("input_conditioner: parameter out of range");
  end

  logic [N_CH-1:0]        raw;
  logic [N_CH-1:0]        s;
  logic [N_CH-1:0]        q;
  logic [N_CH-1:0]        accept;
  logic [SYNC_STAGES-1:0] sync_q [N_CH];
  logic [CNT_W-1:0]       cnt_q  [N_CH];
  logic [N_BTN-1:0]       press;

  // Buttons occupy the low channels, switches the high ones; all share one channel design.
  assign raw = {sw_raw, btn_raw};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign s[i]      = sync_q[i][SYNC_STAGES-1];
    assign accept[i] = (s[i] != q[i]) && (cnt_q[i] == CNT_LAST);
  end

  assign press = accept[N_BTN-1:0] & s[N_BTN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (s[i] == q[i]) begin
          cnt_q[i] <= '0;
        end else if (accept[i]) begin
          q[i]     <= s[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign btn_level = q[N_BTN-1:0];
  assign sw        = q[N_CH-1:N_BTN];

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_q [N_BTN];
  logic [N_BTN-1:0] repeating_q;

  // rep_q counts cycles since the last pulse; the first interval is the delay, later ones the period.
  // An accept while q=1 is a release, which must silence the button on that same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_pulse   <= '0;
      repeating_q <= '0;
      for (int i = 0; i < N_BTN; i++) rep_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_pulse[i] <= press[i];
        if (press[i] || !q[i] || accept[i]) begin
          rep_q[i]       <= '0;
          repeating_q[i] <= 1'b0;
        end else if (rep_q[i] == (repeating_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          btn_pulse[i]   <= 1'b1;
          rep_q[i]       <= '0;
          repeating_q[i] <= 1'b1;
        end else begin
          rep_q[i] <= rep_q[i] + REP_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) btn_pulse <= '0;
    else     btn_pulse <= press;
  end
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random stimulus for input_conditioner, checked every
// cycle against a history-based model of the synchronise/debounce/pulse rules.
module tb_input_conditioner;

  localparam int N_BTN = 5;
  localparam int N_SW  = 16;
  localparam int N_CH  = N_BTN + N_SW;
  localparam int SYNC  = 2;
  localparam int DB    = 4;
  localparam int RD    = 8;
  localparam int RP    = 3;
  localparam int MAXE  = 32768;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_SW-1:0]  sw;

  always #5 clk = ~clk;

  input_conditioner #(
    .N_BTN(N_BTN), .N_SW(N_SW), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .sw(sw)
  );

  int checks = 0;
  int errors = 0;

  // Model state: per-edge history of inputs, plus the model's current outputs.
  bit               rstHist [MAXE];
  logic [N_CH-1:0]  rawHist [MAXE];
  int               edgeCnt = 0;
  logic [N_CH-1:0]  mQ      = '0;
  logic [N_BTN-1:0] mPulse  = '0;
  int               lastPress [N_BTN];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [N_BTN-1:0] b, input logic [N_SW-1:0] s);
    @(negedge clk);
    rst     = r;
    btn_raw = b;
    sw_raw  = s;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic bit inReset(input int e);
    return (e < 0) || rstHist[e];
  endfunction

  // Value seen by the debouncer after edge e: the raw sample from SYNC-1 edges earlier,
  // or 0 if a reset landed anywhere in that window.
  function automatic bit syncedVal(input int e, input int ch);
    for (int k = e - SYNC + 1; k <= e; k++)
      if (inReset(k)) return 1'b0;
    return rawHist[e - SYNC + 1][ch];
  endfunction

  // A new value v is accepted at edge t once the debouncer has seen it for DB straight edges
  // with no reset in between.
  function automatic bit heldLongEnough(input int t, input int ch, input bit v);
    for (int k = t - DB + 1; k <= t; k++)
      if (inReset(k)) return 1'b0;
    for (int e = t - DB; e < t; e++)
      if (syncedVal(e, ch) != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int t;
    logic [N_CH-1:0]  qNew;
    logic [N_BTN-1:0] pNew;
    t = edgeCnt;
    if (t < MAXE) begin
      rstHist[t] = rst;
      rawHist[t] = {sw_raw, btn_raw};
      for (int ch = 0; ch < N_CH; ch++) begin
        if (rst)                               qNew[ch] = 1'b0;
        else if (heldLongEnough(t, ch, !mQ[ch])) qNew[ch] = !mQ[ch];
        else                                   qNew[ch] = mQ[ch];
      end
      pNew = '0;
      for (int i = 0; i < N_BTN; i++) begin
        if (!rst && !mQ[i] && qNew[i]) begin
          pNew[i]      = 1'b1;
          lastPress[i] = t;
        end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
        else if (!rst && mQ[i] && qNew[i] && (t - lastPress[i] >= RD) &&
                 ((t - lastPress[i] - RD) % RP == 0)) begin
          pNew[i] = 1'b1;
        end
`endif
      end
      mQ     = qNew;
      mPulse = pNew;
      edgeCnt++;
      #1;
      checkOutput("model_btn_level", btn_level, mQ[N_BTN-1:0]);
      checkOutput("model_btn_pulse", btn_pulse, mPulse);
      checkOutput("model_sw", sw, mQ[N_CH-1:N_BTN]);
    end
  end

  initial begin
    logic [6:0] bouncePat;
    int         extra;
    int         hold;
    logic [N_BTN-1:0] rb;
    logic [N_SW-1:0]  rs;

    rst     = 1'b1;
    btn_raw = 5'h1F;
    sw_raw  = 16'hFFFF;

    $display("[TB] Test 1: reset with all inputs high");
    for (int j = 0; j < 3; j++) begin
      waitEdges(1);
      checkOutput("t1_rst_level", btn_level, 5'h00);
      checkOutput("t1_rst_pulse", btn_pulse, 5'h00);
      checkOutput("t1_rst_sw", sw, 16'h0000);
    end
    applyStimulus(1'b0, 5'h1F, 16'hFFFF);
    waitEdges(5);
    checkOutput("t1_level_early", btn_level, 5'h00);
    waitEdges(1);
    checkOutput("t1_level", btn_level, 5'h1F);
    checkOutput("t1_sw", sw, 16'hFFFF);
    checkOutput("t1_pulse", btn_pulse, 5'h1F);
    checkOutput("t1_model_level", mQ[N_BTN-1:0], 5'h1F);
    checkOutput("t1_model_pulse", mPulse, 5'h1F);
    waitEdges(1);
    checkOutput("t1_pulse_end", btn_pulse, 5'h00);

    $display("[TB] Test 2: clean press and release");
    applyStimulus(1'b0, 5'h00, 16'hFFFF);
    waitEdges(8);
    applyStimulus(1'b0, 5'h04, 16'hFFFF);
    waitEdges(5);
    checkOutput("t2_level_early", btn_level[2], 1'b0);
    waitEdges(1);
    checkOutput("t2_level", btn_level[2], 1'b1);
    checkOutput("t2_pulse", btn_pulse[2], 1'b1);
    checkOutput("t2_model_pulse", mPulse[2], 1'b1);
    waitEdges(1);
    checkOutput("t2_pulse_end", btn_pulse[2], 1'b0);
    extra = 0;
    for (int j = 7; j <= 39; j++) begin
      waitEdges(1);
      extra += int'(btn_pulse[2]);
    end
`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    checkOutput("t2_extra_pulses", extra, 9);
`else
    checkOutput("t2_extra_pulses", extra, 0);
`endif
    applyStimulus(1'b0, 5'h00, 16'hFFFF);
    waitEdges(5);
    checkOutput("t2_rel_level_early", btn_level[2], 1'b1);
    waitEdges(1);
    checkOutput("t2_rel_level", btn_level[2], 1'b0);
    checkOutput("t2_rel_pulse", btn_pulse[2], 1'b0);

    $display("[TB] Test 3: bounce shorter than the debounce window");
    waitEdges(6);
    bouncePat = 7'b0110111;
    for (int j = 0; j < 7; j++) begin
      applyStimulus(1'b0, {4'b0, bouncePat[j]}, 16'hFFFF);
      waitEdges(1);
      checkOutput("t3_level", btn_level[0], 1'b0);
      checkOutput("t3_pulse", btn_pulse[0], 1'b0);
    end
    applyStimulus(1'b0, 5'h00, 16'hFFFF);
    for (int j = 0; j < 8; j++) begin
      waitEdges(1);
      checkOutput("t3_level_after", btn_level[0], 1'b0);
      checkOutput("t3_pulse_after", btn_pulse[0], 1'b0);
    end

    $display("[TB] Test 4: switch pattern and glitch");
    applyStimulus(1'b0, 5'h00, 16'hA5C3);
    waitEdges(5);
    checkOutput("t4_sw_early", sw, 16'hFFFF);
    waitEdges(1);
    checkOutput("t4_sw", sw, 16'hA5C3);
    checkOutput("t4_model_sw", mQ[N_CH-1:N_BTN], 16'hA5C3);
    applyStimulus(1'b0, 5'h00, 16'hA543);
    waitEdges(2);
    applyStimulus(1'b0, 5'h00, 16'hA5C3);
    for (int j = 0; j < 8; j++) begin
      waitEdges(1);
      checkOutput("t4_sw_glitch", sw, 16'hA5C3);
    end

    $display("[TB] Test 5: simultaneous presses and reset mid-count");
    applyStimulus(1'b0, 5'h11, 16'hA5C3);
    waitEdges(5);
    checkOutput("t5_pulse_early", btn_pulse, 5'h00);
    waitEdges(1);
    checkOutput("t5_pulse", btn_pulse, 5'h11);
    checkOutput("t5_level", btn_level, 5'h11);
    applyStimulus(1'b0, 5'h00, 16'hA5C3);
    waitEdges(8);
    applyStimulus(1'b0, 5'h11, 16'hA5C3);
    waitEdges(3);
    applyStimulus(1'b1, 5'h11, 16'hA5C3);
    waitEdges(1);
    checkOutput("t5_rst_level", btn_level, 5'h00);
    checkOutput("t5_rst_sw", sw, 16'h0000);
    applyStimulus(1'b0, 5'h11, 16'hA5C3);
    for (int j = 0; j < 5; j++) begin
      waitEdges(1);
      checkOutput("t5_no_pulse", btn_pulse, 5'h00);
    end
    waitEdges(1);
    checkOutput("t5_pulse_after_rst", btn_pulse, 5'h11);
    checkOutput("t5_sw_after_rst", sw, 16'hA5C3);
    applyStimulus(1'b0, 5'h00, 16'hA5C3);
    waitEdges(8);

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
    $display("[TB] Test 6: auto-repeat on a held button");
    applyStimulus(1'b0, 5'h02, 16'hA5C3);
    waitEdges(6);
    checkOutput("t6_pulse_press", btn_pulse[1], 1'b1);
    for (int j = 6; j <= 20; j++) begin
      waitEdges(1);
      checkOutput("t6_repeat", btn_pulse[1], (j == 13 || j == 16 || j == 19));
    end
    applyStimulus(1'b0, 5'h00, 16'hA5C3);
    waitEdges(12);
`endif

    $display("[TB] Random phase");
    for (int it = 0; it < 800; it++) begin
      rb   = N_BTN'($urandom);
      rs   = N_SW'($urandom);
      hold = $urandom_range(1, 12);
      applyStimulus(($urandom_range(0, 99) == 0), rb, rs);
      repeat (hold - 1) @(negedge clk);
    end
    applyStimulus(1'b0, 5'h00, 16'h0000);
    waitEdges(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
